seq_calc_unit: RTL

Parametrised multi-cycle arithmetic unit, the next generation of the team's 4-bit single-cycle calculator. Performs add, subtract, multiply and divide on W-bit operands. Exchanges operands and results over valid/ready handshakes, so it can sit between a command source and a result consumer with backpressure. Multiply is shift-add and divide is restoring, each iterating one bit per clock. The result is double-width, and the unit flags divide-by-zero.

---
 rtl/seq_calc_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/seq_calc_unit.sv
// Multi-cycle unsigned add/sub/mul/div unit with valid/ready command and result ports.
// Mul is LSB-first shift-add and div is restoring MSB-first, one bit per clock.
module seq_calc_unit #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [W-1:0] hi,
  output logic         err,
  output logic [1:0]   dbg_state
);

  // Handshake rule: a transfer happens on a rising edge where valid && ready;
  // valid holds its payload stable until that edge, ready never waits on valid.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    op_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  work_hi;
  logic [W-1:0]  work_lo;

  logic          accept;
  logic          done_hs;
  logic [W:0]    add_full;
  logic [W:0]    sub_full;
  logic [W:0]    mul_sum;
  logic [W:0]    div_shift;
  logic [W-1:0]  div_diff;
  logic          div_fit;
  logic [W-1:0]  step_hi;
  logic [W-1:0]  step_lo;

  assign in_ready  = (state == S_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign done_hs   = out_valid && out_ready;
  assign dbg_state = state;

  // Bit W of the widened difference is the borrow (set exactly when a < b).
  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} - {1'b0, b};

  // Mul: work_hi is the running upper product, work_lo shifts the multiplier out.
  // Div: work_hi is the partial remainder, work_lo shifts dividend out / quotient in.
  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, a_q} : {(W+1){1'b0}});
    div_shift = {work_hi, work_lo[W-1]};
    div_fit   = (div_shift >= {1'b0, b_q});
    div_diff  = div_shift[W-1:0] - b_q;
    step_hi   = '0;
    step_lo   = '0;
    if (op_q == OP_MUL) begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], work_lo[W-1:1]};
    end else begin
      step_hi = div_fit ? div_diff : div_shift[W-1:0];
      step_lo = {work_lo[W-2:0], div_fit};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      hi        <= '0;
      err       <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          out_valid <= 1'b0;
          if (accept) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
            cnt  <= '0;
            case (op)
              OP_ADD: begin
                result <= add_full[W-1:0];
                hi     <= {{(W-1){1'b0}}, add_full[W]};
                err    <= 1'b0;
                state  <= S_DONE;
              end
              OP_SUB: begin
                result <= sub_full[W-1:0];
                hi     <= {{(W-1){1'b0}}, sub_full[W]};
                err    <= 1'b0;
                state  <= S_DONE;
              end
              OP_MUL: begin
                work_hi <= '0;
                work_lo <= b;
                state   <= S_RUN;
              end
              default: begin
                if (b == '0) begin
                  result <= '1;
                  hi     <= a;
                  err    <= 1'b1;
                  state  <= S_DONE;
                end else begin
                  work_hi <= '0;
                  work_lo <= a;
                  state   <= S_RUN;
                end
              end
            endcase
          end
        end
        S_RUN: begin
          out_valid <= 1'b0;
          work_hi   <= step_hi;
          work_lo   <= step_lo;
          cnt       <= cnt + 1'b1;
          if (cnt == CW'(W-1)) begin
            result <= step_lo;
            hi     <= step_hi;
            err    <= 1'b0;
            cnt    <= '0;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (done_hs) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
